adder8bit_axil_sched: RTL and testbench

- Two-requester job scheduler that shares one AXI4-Lite 8-bit adder slave.
- Arbitrates round-robin between two add-job requesters.
- Acting as AXI4-Lite master, writes operand A and operand B, reads back the result, then returns it to the winning requester.
- Sits between PL job sources and the adder IP's S00_AXI port, on the same ACLK/ARESETN domain.

---
 rtl/adder8bit_axil_sched.sv | 218 +++++++++++++++++++++
 tb/tb_adder8bit_axil_sched.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder8bit_axil_sched.sv
// Round-robin two-requester job scheduler that drives an AXI4-Lite 8-bit adder slave.
// Define ADDER8_SCHED_STATS_EN to add the saturating jobs_done/jobs_err counters.
module adder8bit_axil_sched #(
  parameter int ADDR_W    = 4,
  parameter int BASE_ADDR = 0
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [7:0]        req0_a,
  input  logic [7:0]        req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [7:0]        req1_a,
  input  logic [7:0]        req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [8:0]        rsp_sum,
  output logic              rsp_err,
`ifdef ADDER8_SCHED_STATS_EN
  output logic [15:0]       jobs_done,
  output logic [7:0]        jobs_err,
`endif
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  localparam logic [ADDR_W-1:0] ADDR_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_B = ADDR_W'(BASE_ADDR + 4);
  localparam logic [ADDR_W-1:0] ADDR_R = ADDR_W'(BASE_ADDR + 8);

  typedef enum logic [2:0] {
    S_IDLE, S_WA, S_WB_A, S_WB, S_WB_B, S_RA, S_RR, S_RESP
  } state_t;

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       id_q, id_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [8:0] sum_q, sum_d;
  logic       err_q, err_d;
  logic       aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic       any_req, grant_id, aw_fin, w_fin;
  logic       unused_rdata;

  assign unused_rdata = ^m_rdata[31:9];
  assign any_req      = req0_valid | req1_valid;
  // The requester that did not win last time gets priority.
  assign grant_id     = last_grant_q ? !req0_valid : req1_valid;
  assign aw_fin       = aw_done_q | m_awready;
  assign w_fin        = w_done_q | m_wready;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      err_q        <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      err_q        <= err_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    err_d        = err_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    case (state_q)
      S_IDLE: if (any_req) begin
        id_d         = grant_id;
        last_grant_d = grant_id;
        a_d          = grant_id ? req1_a : req0_a;
        b_d          = grant_id ? req1_b : req0_b;
        sum_d        = '0;
        err_d        = 1'b0;
        state_d      = S_WA;
      end
      // Address and data channels complete independently; leave once both are done.
      S_WA, S_WB: begin
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (state_q == S_WA) ? S_WB_A : S_WB_B;
        end else begin
          aw_done_d = aw_fin;
          w_done_d  = w_fin;
        end
      end
      S_WB_A, S_WB_B: if (m_bvalid) begin
        if (m_bresp != 2'b00) begin
          err_d   = 1'b1;
          sum_d   = '0;
          state_d = S_RESP;
        end else begin
          state_d = (state_q == S_WB_A) ? S_WB : S_RA;
        end
      end
      S_RA: if (m_arready) state_d = S_RR;
      S_RR: if (m_rvalid) begin
        sum_d   = m_rdata[8:0];
        err_d   = (m_rresp != 2'b00);
        state_d = S_RESP;
      end
      S_RESP: if (rsp_ready) begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    m_awaddr   = '0;
    m_awvalid  = 1'b0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    m_araddr   = '0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req0_ready = any_req && !grant_id;
        req1_ready = any_req && grant_id;
      end
      S_WA, S_WB: begin
        m_awaddr  = (state_q == S_WB) ? ADDR_B : ADDR_A;
        m_awvalid = !aw_done_q;
        m_wdata   = {24'h0, (state_q == S_WB) ? b_q : a_q};
        m_wstrb   = 4'hF;
        m_wvalid  = !w_done_q;
      end
      S_WB_A, S_WB_B: m_bready = 1'b1;
      S_RA: begin
        m_araddr  = ADDR_R;
        m_arvalid = 1'b1;
      end
      S_RR:   m_rready  = 1'b1;
      S_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_id  = id_q;
  assign rsp_sum = sum_q;
  assign rsp_err = err_q;

`ifdef ADDER8_SCHED_STATS_EN
  logic [15:0] jobs_done_q, jobs_done_d;
  logic [7:0]  jobs_err_q, jobs_err_d;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      jobs_done_q <= '0;
      jobs_err_q  <= '0;
    end else begin
      jobs_done_q <= jobs_done_d;
      jobs_err_q  <= jobs_err_d;
    end
  end

  always_comb begin
    jobs_done_d = jobs_done_q;
    jobs_err_d  = jobs_err_q;
    if (state_q == S_RESP && rsp_ready) begin
      if (jobs_done_q != 16'hFFFF) jobs_done_d = jobs_done_q + 16'd1;
      if (err_q && jobs_err_q != 8'hFF) jobs_err_d = jobs_err_q + 8'd1;
    end
  end

  assign jobs_done = jobs_done_q;
  assign jobs_err  = jobs_err_q;
`endif

endmodule

// File: tb/tb_adder8bit_axil_sched.sv
// Bench for adder8bit_axil_sched: behavioural AXI4-Lite adder slave plus per-scenario checking tasks.
module tb_adder8bit_axil_sched;
  localparam int ADDR_W = 4;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b0;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic              req0_ready, req1_ready;
  logic [7:0]        req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic              rsp_valid, rsp_id, rsp_err;
  logic              rsp_ready = 1'b0;
  logic [8:0]        rsp_sum;
  logic [ADDR_W-1:0] m_awaddr, m_araddr;
  logic              m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic              m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [31:0]       m_wdata, m_rdata;
  logic [3:0]        m_wstrb;
  logic [1:0]        m_bresp, m_rresp;
`ifdef ADDER8_SCHED_STATS_EN
  logic [15:0]       jobs_done;
  logic [7:0]        jobs_err;
`endif

  adder8bit_axil_sched #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
`ifdef ADDER8_SCHED_STATS_EN
    .jobs_done(jobs_done), .jobs_err(jobs_err),
`endif
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0, errors = 0;

  // Slave model state
  logic [7:0]        s_reg_a = '0, s_reg_b = '0;
  bit                aw_got, w_got, ar_got, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [ADDR_W-1:0] aw_addr_p, aw_addr_l, ar_addr_p, prev_awaddr, prev_araddr;
  logic [31:0]       wdata_p, wdata_l, prev_wdata;
  bit                prev_aw_wait, prev_w_wait, prev_ar_wait;
  int                aw_cnt, w_cnt;
  int                aw_stall = 0, w_stall = 0;
  bit                rand_mode = 0, err_wa = 0, rresp_rand = 0;
  int                aw_count = 0, ar_count = 0, viol = 0, aw_stall_seen = 0;
  int                rdy0_pulses = 0, rdy1_pulses = 0;
  logic [ADDR_W-1:0] wr_addr_log[$], rd_addr_log[$];
  logic [31:0]       wr_data_log[$];
  bit                rd_err_log[$];

  task automatic slave_clear();
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rresp = 0; m_rdata = 0;
    aw_got = 0; w_got = 0; ar_got = 0;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    aw_cnt = 0; w_cnt = 0;
    prev_aw_wait = 0; prev_w_wait = 0; prev_ar_wait = 0;
  endtask

  // Slave acts at negedge+1: retire handshakes of the last posedge, then set up the next one.
  initial begin
    slave_clear();
    forever begin
      @(negedge ACLK);
      #1;
      if (!ARESETN) slave_clear();
      else begin
        if (aw_hs) begin aw_got = 1; aw_addr_l = aw_addr_p; aw_count++; end
        if (w_hs) begin w_got = 1; wdata_l = wdata_p; end
        if (b_hs) m_bvalid = 0;
        if (ar_hs) begin ar_got = 1; ar_count++; rd_addr_log.push_back(ar_addr_p); end
        if (r_hs) m_rvalid = 0;
        if (aw_hs && m_awvalid) viol++;
        if (w_hs && m_wvalid) viol++;
        if (prev_aw_wait && (!m_awvalid || m_awaddr !== prev_awaddr)) viol++;
        if (prev_w_wait && (!m_wvalid || m_wdata !== prev_wdata)) viol++;
        if (prev_ar_wait && (!m_arvalid || m_araddr !== prev_araddr)) viol++;
        if (m_wvalid && m_wstrb !== 4'hF) viol++;
        if (aw_got && w_got && !m_bvalid) begin
          wr_addr_log.push_back(aw_addr_l);
          wr_data_log.push_back(wdata_l);
          if (aw_addr_l == 4'h0) s_reg_a = wdata_l[7:0];
          else if (aw_addr_l == 4'h4) s_reg_b = wdata_l[7:0];
          m_bresp = (err_wa && aw_addr_l == 4'h0) ? 2'b10 : 2'b00;
          m_bvalid = 1; aw_got = 0; w_got = 0;
        end
        if (ar_got && !m_rvalid) begin
          m_rdata = {23'h0, {1'b0, s_reg_a} + {1'b0, s_reg_b}};
          m_rresp = (rresp_rand && $urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
          rd_err_log.push_back(m_rresp != 2'b00);
          m_rvalid = 1; ar_got = 0;
        end
        if (rand_mode) begin
          m_awready = 1'($urandom_range(0, 1));
          m_wready  = 1'($urandom_range(0, 1));
          m_arready = 1'($urandom_range(0, 1));
        end else begin
          m_awready = (aw_cnt >= aw_stall);
          m_wready  = (w_cnt >= w_stall);
          m_arready = 1'b1;
        end
        if (m_awvalid && !m_awready) begin aw_cnt++; aw_stall_seen++; end else aw_cnt = 0;
        if (m_wvalid && !m_wready) w_cnt++; else w_cnt = 0;
        aw_hs = m_awvalid && m_awready; aw_addr_p = m_awaddr;
        w_hs  = m_wvalid && m_wready;   wdata_p = m_wdata;
        b_hs  = m_bvalid && m_bready;
        ar_hs = m_arvalid && m_arready; ar_addr_p = m_araddr;
        r_hs  = m_rvalid && m_rready;
        prev_aw_wait = m_awvalid && !m_awready; prev_awaddr = m_awaddr;
        prev_w_wait  = m_wvalid && !m_wready;   prev_wdata  = m_wdata;
        prev_ar_wait = m_arvalid && !m_arready; prev_araddr = m_araddr;
        if (req0_ready) rdy0_pulses++;
        if (req1_ready) rdy1_pulses++;
      end
    end
  end

  // Reference arbitration: the requester after the previous winner goes first when both wait.
  function automatic bit rr_pick(bit last, bit v0, bit v1);
    if (v0 && v1) return !last;
    return v1;
  endfunction

  // Called at a negedge; returns at a negedge with the request withdrawn.
  task automatic drive_req(input bit id, input logic [7:0] a, input logic [7:0] b, output bit ok);
    ok = 0;
    if (id == 0) begin req0_valid = 1; req0_a = a; req0_b = b; end
    else begin req1_valid = 1; req1_a = a; req1_b = b; end
    for (int i = 0; i < 300; i++) begin
      #2;
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
        ok = 1;
        @(negedge ACLK);
        break;
      end
      @(negedge ACLK);
    end
    if (id == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic get_rsp(output bit got, output bit id, output logic [8:0] sum, output bit err);
    got = 0; id = 0; sum = '0; err = 0;
    for (int i = 0; i < 300; i++) begin
      #2;
      if (rsp_valid) begin got = 1; break; end
      @(negedge ACLK);
    end
    if (got) begin
      id = rsp_id; sum = rsp_sum; err = rsp_err;
      rsp_ready = 1;
      @(negedge ACLK);
      rsp_ready = 0;
    end
  endtask

  task automatic test_reset();
    ARESETN = 0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_err, m_awvalid, m_wvalid,
         m_bready, m_arvalid, m_rready} !== 19'h0) begin
      errors++; $display("FAIL reset_outputs: got rsp_sum=%h rsp_valid=%b awvalid=%b required all 0",
                         rsp_sum, rsp_valid, m_awvalid);
    end
    repeat (3) @(negedge ACLK);
    ARESETN = 1;
    @(negedge ACLK);
  endtask

  task automatic run_one(input bit rid, input logic [7:0] a, input logic [7:0] b, output bit ok,
                         output bit got, output bit id, output logic [8:0] sum, output bit err);
    fork
      drive_req(rid, a, b, ok);
      get_rsp(got, id, sum, err);
    join
  endtask

  task automatic test_single();
    bit ok, got, id, err; logic [8:0] sum;
    wr_addr_log.delete(); wr_data_log.delete(); rd_addr_log.delete();
    run_one(0, 8'h05, 8'h03, ok, got, id, sum, err);
    checks++;
    if (!(ok && got)) begin errors++; $display("FAIL single_handshake: accepted=%b responded=%b required 1 1", ok, got); end
    checks++;
    if ({id, sum, err} !== {1'b0, 9'h008, 1'b0}) begin
      errors++; $display("FAIL single_rsp: id=%b sum=%h err=%b required 0 008 0", id, sum, err);
    end
    checks++;
    if (wr_addr_log.size() != 2 || rd_addr_log.size() != 1) begin
      errors++; $display("FAIL single_axi_count: writes=%0d reads=%0d required 2 1", wr_addr_log.size(), rd_addr_log.size());
    end else begin
      checks++;
      if ({wr_addr_log[0], wr_data_log[0], wr_addr_log[1], wr_data_log[1], rd_addr_log[0]} !==
          {4'h0, 32'h05, 4'h4, 32'h03, 4'h8}) begin
        errors++; $display("FAIL single_axi_seq: %h/%h %h/%h rd %h required 0/05 4/03 rd 8",
                           wr_addr_log[0], wr_data_log[0], wr_addr_log[1], wr_data_log[1], rd_addr_log[0]);
      end
    end
  endtask

  task automatic test_carry();
    bit ok, got, id, err; logic [8:0] sum;
    run_one(1, 8'hFF, 8'h01, ok, got, id, sum, err);
    checks++;
    if (!(ok && got) || {id, sum, err} !== {1'b1, 9'h100, 1'b0}) begin
      errors++; $display("FAIL carry_rsp: ok=%b got=%b id=%b sum=%h err=%b required 1 1 1 100 0", ok, got, id, sum, err);
    end
  endtask

  task automatic test_contention();
    logic [8:0] exp0[$], exp1[$];
    bit rid[4]; logic [8:0] rsum[4]; bit rgot[4]; bit rerr[4];
    bit last, exp_id; int p0, p1;
    logic [8:0] exp_sum;
    rdy0_pulses = 0; rdy1_pulses = 0;
    fork
      begin
        for (int k = 0; k < 2; k++) begin
          logic [7:0] a, b; bit ok;
          a = 8'($urandom); b = 8'($urandom);
          exp0.push_back({1'b0, a} + {1'b0, b});
          drive_req(0, a, b, ok);
        end
      end
      begin
        for (int k = 0; k < 2; k++) begin
          logic [7:0] a, b; bit ok;
          a = 8'($urandom); b = 8'($urandom);
          exp1.push_back({1'b0, a} + {1'b0, b});
          drive_req(1, a, b, ok);
        end
      end
      begin
        for (int k = 0; k < 4; k++) get_rsp(rgot[k], rid[k], rsum[k], rerr[k]);
      end
    join
    last = 1'b1; p0 = 2; p1 = 2;
    for (int k = 0; k < 4; k++) begin
      exp_id = rr_pick(last, p0 > 0, p1 > 0);
      last = exp_id;
      if (exp_id) begin p1--; exp_sum = exp1.pop_front(); end
      else begin p0--; exp_sum = exp0.pop_front(); end
      checks++;
      if (!rgot[k] || rid[k] !== exp_id || rsum[k] !== exp_sum || rerr[k] !== 1'b0) begin
        errors++; $display("FAIL contention_job%0d: got=%b id=%b sum=%h err=%b required id=%b sum=%h err=0",
                           k, rgot[k], rid[k], rsum[k], rerr[k], exp_id, exp_sum);
      end
    end
    checks++;
    if (rdy0_pulses != 2 || rdy1_pulses != 2) begin
      errors++; $display("FAIL contention_ready_pulses: req0=%0d req1=%0d required 2 2", rdy0_pulses, rdy1_pulses);
    end
  endtask

  task automatic test_backpressure();
    bit ok, got, id, err; logic [8:0] sum, exp_sum; logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom); exp_sum = {1'b0, a} + {1'b0, b};
    aw_stall = 3; w_stall = 0; viol = 0; aw_stall_seen = 0;
    fork
      drive_req(0, a, b, ok);
      begin
        got = 0;
        for (int i = 0; i < 300; i++) begin
          #2;
          if (rsp_valid) begin got = 1; break; end
          @(negedge ACLK);
        end
        id = rsp_id; sum = rsp_sum; err = rsp_err;
        for (int h = 0; h < 5; h++) begin
          @(negedge ACLK); #2;
          checks++;
          if (!rsp_valid || rsp_id !== id || rsp_sum !== sum || rsp_err !== err) begin
            errors++; $display("FAIL rsp_hold_cycle%0d: valid=%b id=%b sum=%h err=%b required 1 %b %h %b",
                               h, rsp_valid, rsp_id, rsp_sum, rsp_err, id, sum, err);
          end
        end
        rsp_ready = 1;
        @(negedge ACLK);
        rsp_ready = 0;
      end
    join
    aw_stall = 0;
    checks++;
    if (!got || {id, sum, err} !== {1'b0, exp_sum, 1'b0}) begin
      errors++; $display("FAIL backpressure_rsp: got=%b id=%b sum=%h err=%b required 1 0 %h 0", got, id, sum, err, exp_sum);
    end
    checks++;
    if (aw_stall_seen != 6) begin
      errors++; $display("FAIL aw_stall_cycles: saw %0d required 6", aw_stall_seen);
    end
    checks++;
    if (viol != 0) begin
      errors++; $display("FAIL axi_valid_rules: %0d violations required 0", viol);
    end
  endtask

  task automatic test_error();
    bit ok, got, id, err; logic [8:0] sum; int aw0, ar0;
    err_wa = 1; aw0 = aw_count; ar0 = ar_count;
    run_one(0, 8'h12, 8'h34, ok, got, id, sum, err);
    err_wa = 0;
    repeat (3) @(negedge ACLK);
    checks++;
    if (!got || err !== 1'b1 || sum !== 9'h000) begin
      errors++; $display("FAIL error_rsp: got=%b err=%b sum=%h required 1 1 000", got, err, sum);
    end
    checks++;
    if (aw_count - aw0 != 1 || ar_count - ar0 != 0) begin
      errors++; $display("FAIL error_no_traffic: aw=%0d ar=%0d required 1 0", aw_count - aw0, ar_count - ar0);
    end
`ifdef ADDER8_SCHED_STATS_EN
    checks++;
    if (jobs_err !== 8'd1 || jobs_done !== 16'd8) begin
      errors++; $display("FAIL stats_counts: jobs_err=%0d jobs_done=%0d required 1 8", jobs_err, jobs_done);
    end
`endif
    run_one(1, 8'h80, 8'h80, ok, got, id, sum, err);
    checks++;
    if (!got || {id, sum, err} !== {1'b1, 9'h100, 1'b0}) begin
      errors++; $display("FAIL error_cleared: got=%b id=%b sum=%h err=%b required 1 1 100 0", got, id, sum, err);
    end
  endtask

  task automatic test_random();
    localparam int N = 10;
    logic [8:0] exp0[$], exp1[$];
    bit rid[2*N]; logic [8:0] rsum[2*N]; bit rgot[2*N]; bit rerr[2*N];
    logic [8:0] exp_sum;
    rand_mode = 1; rresp_rand = 1; rd_err_log.delete(); viol = 0;
    fork
      begin
        for (int k = 0; k < N; k++) begin
          logic [7:0] a, b; bit ok;
          a = 8'($urandom); b = 8'($urandom);
          exp0.push_back({1'b0, a} + {1'b0, b});
          drive_req(0, a, b, ok);
          repeat ($urandom_range(0, 8)) @(negedge ACLK);
        end
      end
      begin
        for (int k = 0; k < N; k++) begin
          logic [7:0] a, b; bit ok;
          a = 8'($urandom); b = 8'($urandom);
          exp1.push_back({1'b0, a} + {1'b0, b});
          drive_req(1, a, b, ok);
          repeat ($urandom_range(0, 8)) @(negedge ACLK);
        end
      end
      begin
        for (int k = 0; k < 2*N; k++) get_rsp(rgot[k], rid[k], rsum[k], rerr[k]);
      end
    join
    rand_mode = 0; rresp_rand = 0;
    for (int k = 0; k < 2*N; k++) begin
      checks++;
      if (!rgot[k] || (rid[k] ? exp1.size() : exp0.size()) == 0 || k >= rd_err_log.size()) begin
        errors++; $display("FAIL random_job%0d_missing: got=%b id=%b", k, rgot[k], rid[k]);
        continue;
      end
      exp_sum = rid[k] ? exp1.pop_front() : exp0.pop_front();
      if (rsum[k] !== exp_sum || rerr[k] !== rd_err_log[k]) begin
        errors++; $display("FAIL random_job%0d: id=%b sum=%h err=%b required sum=%h err=%b",
                           k, rid[k], rsum[k], rerr[k], exp_sum, rd_err_log[k]);
      end
    end
    checks++;
    if (viol != 0) begin
      errors++; $display("FAIL random_axi_rules: %0d violations required 0", viol);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, got, seen, id0, id1, e0, e1, g0, g1; logic [8:0] s0, s1;
    seen = 0;
    fork
      drive_req(0, 8'h21, 8'h43, ok);
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge ACLK); #2;
          if (m_rready) begin seen = 1; break; end
        end
        ARESETN = 0;
        #1;
      end
    join
    checks++;
    if (!seen || {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_err, m_awvalid, m_wvalid,
                  m_bready, m_arvalid, m_rready} !== 19'h0) begin
      errors++; $display("FAIL reset_mid_rr: reached_rr=%b rready=%b rsp_valid=%b required 1 0 0", seen, m_rready, rsp_valid);
    end
`ifdef ADDER8_SCHED_STATS_EN
    checks++;
    if (jobs_done !== 16'd0 || jobs_err !== 8'd0) begin
      errors++; $display("FAIL stats_reset: jobs_done=%0d jobs_err=%0d required 0 0", jobs_done, jobs_err);
    end
`endif
    repeat (2) @(negedge ACLK);
    ARESETN = 1;
    @(negedge ACLK);
    fork
      drive_req(0, 8'h10, 8'h20, ok);
      drive_req(1, 8'h30, 8'h40, got);
      begin
        get_rsp(g0, id0, s0, e0);
        get_rsp(g1, id1, s1, e1);
      end
    join
    checks++;
    if (!g0 || {id0, s0, e0} !== {1'b0, 9'h030, 1'b0}) begin
      errors++; $display("FAIL post_reset_first: got=%b id=%b sum=%h err=%b required 1 0 030 0", g0, id0, s0, e0);
    end
    checks++;
    if (!g1 || {id1, s1, e1} !== {1'b1, 9'h070, 1'b0}) begin
      errors++; $display("FAIL post_reset_second: got=%b id=%b sum=%h err=%b required 1 1 070 0", g1, id1, s1, e1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge ACLK);
    test_reset();
    test_single();
    test_carry();
    test_contention();
    test_backpressure();
    test_error();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
